// File: rtl/song_sequencer.sv
// song_sequencer: walks a 32-entry song ROM and times each note in beats; optional SONG_SEQ_REPEAT_EN loops the song.
// Latency: ROM address is presented in FETCH, and the note is registered two cycles after the sequencer leaves IDLE or HOLD.
// Backpressure: play=0 only freezes beat counting in HOLD; FETCH and DECODE always complete.
module song_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        play,
    input  logic        reset_player,
    input  logic [1:0]  song,
    input  logic        beat,
    output logic [6:0]  rom_addr,
    input  logic [11:0] rom_data,
    output logic [5:0]  note_out,
    output logic        new_note,
    output logic        note_active,
    output logic        song_done
);

`ifdef SONG_SEQ_REPEAT_EN
    localparam logic REPEAT_EN = 1'b1;
`else
    localparam logic REPEAT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        HOLD   = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  song_latched, song_latched_nxt;
    logic [4:0]  note_idx, note_idx_nxt;
    logic [5:0]  dur_cnt, dur_cnt_nxt;
    logic [5:0]  note_out_nxt;
    logic        new_note_nxt;
    logic        song_done_nxt;

    logic [5:0]  rom_note;
    logic [5:0]  rom_dur;

    assign rom_note    = rom_data[11:6];
    assign rom_dur     = rom_data[5:0];
    assign rom_addr    = {song_latched, note_idx};
    assign note_active = (state == HOLD) && play;

    always_comb begin
        state_nxt        = state;
        song_latched_nxt = song_latched;
        note_idx_nxt     = note_idx;
        dur_cnt_nxt      = dur_cnt;
        note_out_nxt     = note_out;
        new_note_nxt     = 1'b0;
        song_done_nxt    = 1'b0;

        // A player clear wins over everything, including a strobe due this edge.
        if (reset_player) begin
            state_nxt    = IDLE;
            note_idx_nxt = 5'd0;
            dur_cnt_nxt  = 6'd0;
            note_out_nxt = 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (play) begin
                        song_latched_nxt = song;
                        state_nxt        = FETCH;
                    end
                end
                FETCH: begin
                    state_nxt = DECODE;
                end
                DECODE: begin
                    if (rom_dur != 6'd0) begin
                        note_out_nxt = rom_note;
                        dur_cnt_nxt  = rom_dur;
                        new_note_nxt = 1'b1;
                        state_nxt    = HOLD;
                    end else begin
                        note_idx_nxt  = 5'd0;
                        note_out_nxt  = 6'd0;
                        song_done_nxt = !REPEAT_EN;
                        state_nxt     = DONE;
                    end
                end
                HOLD: begin
                    if (beat && play) begin
                        dur_cnt_nxt = dur_cnt - 6'd1;
                        if (dur_cnt == 6'd1) begin
                            // note_idx wraps naturally; a wrap means all 32 slots were played.
                            note_idx_nxt = note_idx + 5'd1;
                            if (note_idx == 5'd31) begin
                                note_out_nxt  = 6'd0;
                                song_done_nxt = !REPEAT_EN;
                                state_nxt     = DONE;
                            end else begin
                                state_nxt = FETCH;
                            end
                        end
                    end
                end
                DONE: begin
                    note_idx_nxt = 5'd0;
                    state_nxt    = REPEAT_EN ? FETCH : IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            song_latched <= 2'd0;
            note_idx     <= 5'd0;
            dur_cnt      <= 6'd0;
            note_out     <= 6'd0;
            new_note     <= 1'b0;
            song_done    <= 1'b0;
        end else begin
            state        <= state_nxt;
            song_latched <= song_latched_nxt;
            note_idx     <= note_idx_nxt;
            dur_cnt      <= dur_cnt_nxt;
            note_out     <= note_out_nxt;
            new_note     <= new_note_nxt;
            song_done    <= song_done_nxt;
        end
    end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: transaction-level player model with per-cycle compare, directed scenarios and random play.
module tb_song_sequencer;

`ifdef SONG_SEQ_REPEAT_EN
    localparam bit REPEAT = 1'b1;
`else
    localparam bit REPEAT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        play;
    logic        reset_player;
    logic [1:0]  song;
    logic        beat;
    logic [6:0]  rom_addr;
    logic [11:0] rom_data;
    logic [5:0]  note_out;
    logic        new_note;
    logic        note_active;
    logic        song_done;

    song_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .reset_player (reset_player),
        .song         (song),
        .beat         (beat),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .note_out     (note_out),
        .new_note     (new_note),
        .note_active  (note_active),
        .song_done    (song_done)
    );

    always #5 clk = ~clk;

    logic [11:0] rom [0:127];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int beat_period = 0;
    int done_cnt = 0;
    int seen_notes[$];
    logic [6:0] done_addr = 7'd0;

    // Player model: running flag, cycles left before the next note lands, beats left on the current note.
    bit m_run, m_endph, m_new, m_done;
    int m_lat, m_rem, m_idx, m_song, m_note;

    function void model_clear_player();
        m_run = 0; m_endph = 0; m_new = 0; m_done = 0;
        m_lat = 0; m_rem = 0; m_idx = 0; m_note = 0;
    endfunction

    function void model_clear();
        model_clear_player();
        m_song = 0;
    endfunction

    function void finish_song();
        m_idx   = 0;
        m_note  = 0;
        m_endph = 1;
        m_done  = !REPEAT;
    endfunction

    function void model_advance();
        int entry;
        if (!reset) begin
            model_clear();
        end else if (reset_player) begin
            model_clear_player();
        end else begin
            m_new  = 0;
            m_done = 0;
            if (m_endph) begin
                m_endph = 0;
                if (REPEAT) m_lat = 2;
                else        m_run = 0;
            end else if (!m_run) begin
                if (play) begin
                    m_run  = 1;
                    m_song = int'(song);
                    m_lat  = 2;
                end
            end else if (m_lat > 0) begin
                m_lat = m_lat - 1;
                if (m_lat == 0) begin
                    entry = int'(rom[m_song * 32 + m_idx]);
                    if (entry % 64 == 0) begin
                        finish_song();
                    end else begin
                        m_note = entry / 64;
                        m_rem  = entry % 64;
                        m_new  = 1;
                    end
                end
            end else if (beat && play) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_idx = (m_idx + 1) % 32;
                    if (m_idx == 0) finish_song();
                    else            m_lat = 2;
                end
            end
        end
    endfunction

    task automatic compare_cycle();
        logic [15:0] exp_v;
        logic [15:0] act_v;
        bit exp_act;
        exp_act = m_run && (m_lat == 0) && !m_endph && (play == 1'b1);
        exp_v = {2'(m_song), 5'(m_idx), 6'(m_note), m_new, exp_act, m_done};
        act_v = {rom_addr, note_out, new_note, note_active, song_done};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL cycle%0d: dut addr=%h note=%0d new=%b act=%b done=%b, model addr=%h note=%0d new=%b act=%b done=%b",
                     cyc, act_v[15:9], act_v[8:3], act_v[2], act_v[1], act_v[0],
                     exp_v[15:9], exp_v[8:3], exp_v[2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic timeout(string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic step();
        @(posedge clk);
        model_advance();
        @(negedge clk);
        compare_cycle();
        cyc++;
        if (new_note)  seen_notes.push_back(int'(note_out));
        if (song_done) begin
            done_cnt++;
            done_addr = rom_addr;
        end
        if (beat_period > 0) beat = (cyc % beat_period) == 0;
    endtask

    task automatic clear_player();
        play = 1'b0;
        beat = 1'b0;
        beat_period = 0;
        reset_player = 1'b1;
        step();
        reset_player = 1'b0;
        seen_notes.delete();
        done_cnt = 0;
    endtask

    task automatic wait_new_note(int budget, string name);
        for (int n = 0; n < budget; n++) begin
            step();
            if (new_note) return;
        end
        timeout(name);
    endtask

    task automatic run_until_done(int budget, string name);
        for (int n = 0; n < budget; n++) begin
            step();
            if (done_cnt > 0) return;
        end
        timeout(name);
    endtask

    initial begin
        int beats;
        int bad_song;
        bit found;
        reset = 1'b0;
        play = 1'b0;
        reset_player = 1'b0;
        song = 2'd0;
        beat = 1'b0;
        for (int i = 0; i < 128; i++) rom[i] = 12'd0;
        model_clear();

        repeat (2) step();
        check("reset rom_addr", int'(rom_addr), 0);
        check("reset note_out", int'(note_out), 0);
        check("reset strobes", int'({new_note, note_active, song_done}), 0);
        reset = 1'b1;
        step();
        check("idle after release", int'({rom_addr, note_out, new_note, note_active, song_done}), 0);

`ifndef SONG_SEQ_REPEAT_EN
        // Song 1: note 10 for 2 beats, note 20 for 1 beat, then end marker.
        clear_player();
        rom[32] = {6'd10, 6'd2};
        rom[33] = {6'd20, 6'd1};
        rom[34] = 12'd0;
        song = 2'd1;
        beat_period = 4;
        play = 1'b1;
        run_until_done(200, "song1 done");
        check("song1 note count", seen_notes.size(), 2);
        if (seen_notes.size() == 2) begin
            check("song1 first note", seen_notes[0], 10);
            check("song1 second note", seen_notes[1], 20);
        end
        check("song1 done pulses", done_cnt, 1);
        check("song1 done addr", int'(done_addr), 'h20);

        // Pause for 10 beats in the middle of a 3-beat note.
        clear_player();
        rom[64] = {6'd7, 6'd3};
        rom[65] = 12'd0;
        song = 2'd2;
        play = 1'b1;
        wait_new_note(20, "pause first note");
        check("pause note value", int'(note_out), 7);
        beat = 1'b1;
        step();
        beat = 1'b0;
        play = 1'b0;
        for (int i = 0; i < 40; i++) begin
            beat = (i % 4) == 0;
            step();
        end
        beat = 1'b0;
        check("pause note held", int'(note_out), 7);
        check("pause note_active", int'(note_active), 0);
        check("pause no new note", seen_notes.size(), 1);
        play = 1'b1;
        beats = 0;
        for (int k = 0; k < 10 && done_cnt == 0; k++) begin
            beat = 1'b1;
            step();
            beats++;
            beat = 1'b0;
            repeat (3) step();
        end
        check("pause remaining beats", beats, 2);
        check("pause done pulses", done_cnt, 1);

        // reset_player while holding note index 5.
        clear_player();
        for (int i = 0; i < 8; i++) rom[64 + i] = {6'(i + 1), 6'd2};
        rom[72] = 12'd0;
        song = 2'd2;
        beat_period = 3;
        play = 1'b1;
        found = 0;
        for (int n = 0; n < 300 && !found; n++) begin
            step();
            found = new_note && (rom_addr[4:0] == 5'd5);
        end
        if (!found) timeout("rp reach note 5");
        reset_player = 1'b1;
        step();
        reset_player = 1'b0;
        play = 1'b0;
        check("rp rom_addr", int'(rom_addr), 64);
        check("rp note_out", int'(note_out), 0);
        check("rp note_active", int'(note_active), 0);
        repeat (5) step();
        check("rp no song_done", done_cnt, 0);

        // 32 full entries, no end marker: completion by index wrap.
        clear_player();
        for (int i = 0; i < 32; i++) rom[96 + i] = {6'(i + 1), 6'd1};
        song = 2'd3;
        beat_period = 2;
        play = 1'b1;
        run_until_done(1000, "wrap done");
        check("wrap note count", seen_notes.size(), 32);
        if (seen_notes.size() == 32) check("wrap last note", seen_notes[31], 32);
        check("wrap done pulses", done_cnt, 1);
        check("wrap done addr", int'(done_addr), 96);

        // Song select change while a song is running.
        clear_player();
        rom[32] = {6'd10, 6'd2};
        rom[33] = {6'd20, 6'd1};
        rom[34] = 12'd0;
        song = 2'd1;
        beat_period = 4;
        play = 1'b1;
        wait_new_note(20, "songchg first note");
        song = 2'd3;
        bad_song = 0;
        for (int n = 0; n < 200 && done_cnt == 0; n++) begin
            step();
            if (rom_addr[6:5] != 2'd1) bad_song++;
        end
        check("songchg latched song", bad_song, 0);
        check("songchg done", done_cnt, 1);
        repeat (2) step();
        check("songchg relatch", int'(rom_addr[6:5]), 3);
`else
        // Two-note song loops without ever reporting completion.
        clear_player();
        rom[0] = {6'd5, 6'd1};
        rom[1] = {6'd9, 6'd2};
        rom[2] = 12'd0;
        song = 2'd0;
        beat_period = 2;
        play = 1'b1;
        repeat (1000) step();
        check("repeat no song_done", done_cnt, 0);
        check("repeat many notes", int'(seen_notes.size() >= 100), 1);
        if (seen_notes.size() >= 3) begin
            check("repeat note0", seen_notes[0], 5);
            check("repeat note1", seen_notes[1], 9);
            check("repeat note2", seen_notes[2], 5);
        end
`endif

        // Random play/beat/clear/song traffic over a random ROM.
        clear_player();
        for (int i = 0; i < 128; i++) begin
            if ($urandom_range(0, 11) == 0) rom[i] = {6'($urandom_range(0, 63)), 6'd0};
            else rom[i] = {6'($urandom_range(0, 63)), 6'($urandom_range(1, 3))};
        end
        for (int i = 0; i < 3000; i++) begin
            play = $urandom_range(0, 7) != 0;
            beat = $urandom_range(0, 2) == 0;
            reset_player = $urandom_range(0, 79) == 0;
            if ($urandom_range(0, 49) == 0) song = 2'($urandom_range(0, 3));
            if (i == 1500) begin
                #2;
                reset = 1'b0;
                model_clear();
                #1;
                compare_cycle();
                check("async reset rom_addr", int'(rom_addr), 0);
                check("async reset note_out", int'(note_out), 0);
                step();
                reset = 1'b1;
            end else begin
                step();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/song_sequencer.md
SONG_SEQUENCER -- requirements
Module: song_sequencer

Interface
REQ-001 The block SHALL have these ports, one per line: name  direction  width  meaning.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset: 0 = in reset.
REQ-004 play  in  1  level from the control unit; 1 = run or continue, 0 = pause.
REQ-005 reset_player  in  1  synchronous clear from the control unit; has priority over all other inputs.
REQ-006 song  in  2  song select; latched on leaving IDLE.
REQ-007 beat  in  1  one-cycle tick at the beat rate.
REQ-008 rom_addr  out  7  {song_latched[1:0], note_idx[4:0]} to the song ROM.
REQ-009 rom_data  in  12  ROM word: [11:6] note (0 = rest), [5:0] duration in beats (0 = end-of-song marker).
REQ-010 note_out  out  6  current note to the note player.
REQ-011 new_note  out  1  one-cycle strobe marking a new note_out.
REQ-012 note_active  out  1  high while a note is being timed and play=1.
REQ-013 song_done  out  1  one-cycle strobe at end of song.

Function
REQ-014 The FSM SHALL have states IDLE, FETCH, DECODE, HOLD and DONE.
REQ-015 IDLE: on play=1, latch song and go to FETCH; otherwise stay in IDLE.
REQ-016 FETCH: rom_addr SHALL be valid, and the ROM returns rom_data one cycle later; go to DECODE.
REQ-017 DECODE, duration!=0: register note_out and load dur_cnt with the duration, then go to HOLD.
REQ-018 DECODE, duration==0: go to DONE without asserting new_note.
REQ-019 new_note SHALL be high for exactly the first cycle of each HOLD entry; rest notes (note=0) still strobe.
REQ-020 HOLD: beat=1 with play=1 decrements dur_cnt, and beat with play=0 is ignored.
REQ-021 HOLD, dur_cnt==1 with beat=1 and play=1: increment note_idx mod 32; go to FETCH, or to DONE if note_idx wraps from 31 to 0.
REQ-022 note_active SHALL equal (state==HOLD && play); note_out holds its value while paused.
REQ-023 DONE: song_done=1 for one cycle, note_idx=0, note_out=0; go to IDLE.
REQ-024 A play drop in FETCH or DECODE SHALL NOT stall the FSM; it proceeds to HOLD and pauses there.
REQ-025 A song change after latching SHALL be ignored until the FSM next leaves IDLE.
REQ-026 reset_player=1 SHALL, on the next edge in any state, force IDLE, note_idx=0, dur_cnt=0, note_out=0, new_note=0, song_done=0.
REQ-027 reset_player SHALL override a same-cycle song_done or new_note.

Reset
REQ-028 reset=0 SHALL asynchronously force IDLE, note_idx=0, song_latched=0, dur_cnt=0, note_out=0, new_note=0, note_active=0, song_done=0, rom_addr=0.
REQ-029 Release SHALL be synchronous-safe: the first FSM transition occurs on the first edge with reset=1.

Configuration
REQ-030 Macro SONG_SEQ_REPEAT_EN, when defined: DONE SHALL go to FETCH with note_idx=0 and song_done SHALL never assert.
REQ-031 Macro SONG_SEQ_REPEAT_EN, when undefined: behaviour SHALL be as REQ-023.

Verification
REQ-032 Song 1 ROM {note 10 dur 2, note 20 dur 1, dur 0}, play=1, beat every 4 cycles -> new_note with note_out=10, then 20 after 2 beats, then song_done one cycle, rom_addr back to 7'h20.
REQ-033 play=0 for 10 beats mid-HOLD -> note_out unchanged, note_active=0, dur_cnt frozen; resumes the remaining beats on play=1.
REQ-034 reset_player pulse during HOLD of note 5 -> next cycle IDLE, note_out=0, rom_addr={song,5'd0}; no song_done.
REQ-035 32 nonzero-duration entries, no end marker -> song_done after the 32nd note; note_idx=0.
REQ-036 song changed 1->3 during HOLD -> rom_addr upper bits stay 2'b01 until DONE/IDLE.
REQ-037 SONG_SEQ_REPEAT_EN defined, 2-note song -> the notes loop continuously; song_done stays 0 for 1000 cycles.
